// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: opcodes, condition codes,
// flag bit positions, FSM state encodings and instruction field positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam logic [1:0] COND_AL = 2'b00;
  localparam logic [1:0] COND_Z  = 2'b01;
  localparam logic [1:0] COND_C  = 2'b10;
  localparam logic [1:0] COND_N  = 2'b11;

  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 1;
  localparam int FLG_V = 0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_CAPT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  // Instruction field low bit positions (fields are read with +: slices).
  localparam int INS_LDI   = 15;
  localparam int LDI_RD_LO = 13;
  localparam int IMM_LO    = 0;
  localparam int OP_LO     = 12;
  localparam int RD_LO     = 10;
  localparam int RA_LO     = 8;
  localparam int RB_LO     = 6;
  localparam int COND_LO   = 4;
  localparam int FUPD_BIT  = 3;

  function automatic logic cond_ok(input logic [1:0] cond, input logic [3:0] flags);
    logic ok;
    case (cond)
      COND_Z:  ok = flags[FLG_Z];
      COND_C:  ok = flags[FLG_C];
      COND_N:  ok = flags[FLG_N];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_regfile_4x8.sv
// 4-entry register file: one write port, two read ports sampled on rd_en,
// and a combinational debug read port.
module alu_regfile_4x8 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [1:0]        raddr_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports hold their last sampled value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (rd_en) begin
      rdata_a <= regs[raddr_a];
      rdata_b <= regs[raddr_b];
    end
  end

  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential front-end for the combinational ALU: accept, issue, capture, respond.
// Optional perf counters are built when ALU_PERF_CNT_EN is defined.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_flags,
  output logic              rsp_skipped,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  output logic [3:0]        status,
  input  logic [1:0]        dbg_sel,
`ifdef ALU_PERF_CNT_EN
  output logic [CNT_W-1:0]  perf_exec,
  output logic [CNT_W-1:0]  perf_skip,
`endif
  output logic [1:0]        dbg_state,
  output logic [DATA_W-1:0] dbg_data
);

  // Both handshakes transfer on a rising edge where valid && ready; the
  // initiator holds its payload stable while valid is high and ready is low.
  state_t      state;
  logic [15:0] instr_q;
  logic        cond_pass;
  logic        fire;
  logic        is_ldi;
  logic [3:0]  alu_flags;
  logic        rf_we;
  logic [1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] imm;

  assign instr_ready = (state == ST_IDLE);
  assign fire        = instr_valid && instr_ready;
  assign is_ldi      = instr_q[INS_LDI];
  assign imm         = DATA_W'(instr_q[IMM_LO +: 8]);
  assign alu_flags   = {alu_carry, alu_zero, alu_negative, alu_overflow};
  assign dbg_state   = state;

  assign rf_we    = (state == ST_CAPT) && (is_ldi || cond_pass);
  assign rf_waddr = is_ldi ? instr_q[LDI_RD_LO +: 2] : instr_q[RD_LO +: 2];
  assign rf_wdata = is_ldi ? imm : alu_result;

  alu_regfile_4x8 #(.DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .rd_en    (state == ST_ISSUE),
    .raddr_a  (instr_q[RA_LO +: 2]),
    .raddr_b  (instr_q[RB_LO +: 2]),
    .rdata_a  (alu_a),
    .rdata_b  (alu_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      instr_q     <= '0;
      cond_pass   <= 1'b0;
      alu_op      <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_flags   <= '0;
      rsp_skipped <= 1'b0;
      status      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fire) begin
            instr_q   <= instr;
            // Only one instruction is in flight, so status here is pre-instruction.
            cond_pass <= cond_ok(instr[COND_LO +: 2], status);
            state     <= instr[INS_LDI] ? ST_CAPT : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_op <= instr_q[OP_LO +: 3];
          state  <= ST_CAPT;
        end
        ST_CAPT: begin
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
          if (is_ldi) begin
            rsp_data    <= imm;
            rsp_flags   <= status;
            rsp_skipped <= 1'b0;
          end else begin
            rsp_flags <= alu_flags;
            if (cond_pass) begin
              rsp_data    <= alu_result;
              rsp_skipped <= 1'b0;
              if (instr_q[FUPD_BIT]) status <= alu_flags;
            end else begin
              rsp_data    <= '0;
              rsp_skipped <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_exec <= '0;
      perf_skip <= '0;
    end else if (state == ST_CAPT) begin
      if (rf_we) begin
        if (perf_exec != '1) perf_exec <= perf_exec + 1'b1;
      end else begin
        if (perf_skip != '1) perf_skip <= perf_skip + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the issue side.
// Perf counter checks are built when ALU_PERF_CNT_EN is defined.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [15:0]   instr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [3:0]    rsp_flags;
  logic          rsp_skipped;
  logic [DW-1:0] alu_a, alu_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_result;
  logic          alu_carry, alu_zero, alu_negative, alu_overflow;
  logic [3:0]    status;
  logic [1:0]    dbg_sel = '0;
  logic [1:0]    dbg_state;
  logic [DW-1:0] dbg_data;
`ifdef ALU_PERF_CNT_EN
  logic [CW-1:0] perf_exec, perf_skip;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_flags    (rsp_flags),
    .rsp_skipped  (rsp_skipped),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .status       (status),
    .dbg_sel      (dbg_sel),
`ifdef ALU_PERF_CNT_EN
    .perf_exec    (perf_exec),
    .perf_skip    (perf_skip),
`endif
    .dbg_state    (dbg_state),
    .dbg_data     (dbg_data)
  );

  // Behavioural ALU; carry on SUB means borrow.
  logic [DW:0] alu_wide;
  always_comb begin
    alu_wide      = '0;
    alu_result    = '0;
    alu_carry     = 1'b0;
    alu_overflow  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_wide     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = alu_wide[DW-1:0];
        alu_carry    = alu_wide[DW];
        alu_overflow = (alu_a[DW-1] == alu_b[DW-1]) && (alu_result[DW-1] != alu_a[DW-1]);
      end
      OP_SUB: begin
        alu_wide     = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result   = alu_wide[DW-1:0];
        alu_carry    = alu_wide[DW];
        alu_overflow = (alu_a[DW-1] != alu_b[DW-1]) && (alu_result[DW-1] != alu_a[DW-1]);
      end
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_NOT: alu_result = ~alu_a;
      OP_SHL: begin alu_result = alu_a << 1; alu_carry = alu_a[DW-1]; end
      default: begin alu_result = alu_a >> 1; alu_carry = alu_a[0]; end
    endcase
  end
  assign alu_zero     = (alu_result == '0);
  assign alu_negative = alu_result[DW-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {1'b1, rd, 5'b0, imm};
  endfunction

  function automatic logic [15:0] enc_alu(input logic [2:0] op, input logic [1:0] rd,
                                          input logic [1:0] ra, input logic [1:0] rb,
                                          input logic [1:0] cond, input logic fupd);
    return {1'b0, op, rd, ra, rb, cond, fupd, 3'b000};
  endfunction

  task automatic read_reg(input logic [1:0] idx, output logic [DW-1:0] val);
    dbg_sel = idx;
    #1 val = dbg_data;
  endtask

  // Drives one instruction, measures handshake-to-response latency in cycles
  // (handshake cycle counted), optionally stalls the response while offering
  // an intruding instruction, then completes the response.
  task automatic run_instr(input logic [15:0] w, input int hold,
                           output logic [DW-1:0] d, output logic [3:0] f,
                           output logic s, output int lat);
    int guard;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!instr_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    lat = 1;
    #1 instr_valid = 1'b0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    d = rsp_data;
    f = rsp_flags;
    s = rsp_skipped;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      instr = enc_ldi(2'd3, 8'hAA);
      instr_valid = 1'b1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(d));
      check("hold_ready", 32'(instr_ready), 32'd0);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  logic [DW-1:0] d, r;
  logic [3:0]    f;
  logic          s;
  int            lat;

  initial begin
    // Reset state
    #12;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_rsp_skipped", 32'(rsp_skipped), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), r);
      check("rst_reg", 32'(r), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // 0x7F + 0x01 signed overflow
    run_instr(enc_ldi(2'd0, 8'h7F), 0, d, f, s, lat);
    check("ldi_lat", lat, 2);
    check("ldi_data", 32'(d), 32'h7F);
    check("ldi_flags", 32'(f), 32'h0);
    run_instr(enc_ldi(2'd1, 8'h01), 0, d, f, s, lat);
    run_instr(enc_alu(OP_ADD, 2'd2, 2'd0, 2'd1, COND_AL, 1'b1), 0, d, f, s, lat);
    check("add_lat", lat, 3);
    check("add_data", 32'(d), 32'h80);
    check("add_flags", 32'(f), 32'b0011);
    check("add_skipped", 32'(s), 32'd0);
    check("add_status", 32'(status), 32'b0011);
    read_reg(2'd2, r);
    check("add_reg2", 32'(r), 32'h80);

    // Zero result, then conditional execution against it
    run_instr(enc_ldi(2'd0, 8'h05), 0, d, f, s, lat);
    check("ldi_flags_status", 32'(f), 32'b0011);
    check("ldi_keeps_status", 32'(status), 32'b0011);
    run_instr(enc_alu(OP_SUB, 2'd3, 2'd0, 2'd0, COND_AL, 1'b1), 0, d, f, s, lat);
    check("sub_data", 32'(d), 32'h00);
    check("sub_flags", 32'(f), 32'b0100);
    check("sub_status", 32'(status), 32'b0100);
    run_instr(enc_alu(OP_ADD, 2'd0, 2'd0, 2'd0, COND_Z, 1'b0), 0, d, f, s, lat);
    check("condz_data", 32'(d), 32'h0A);
    check("condz_skipped", 32'(s), 32'd0);
    check("condz_status", 32'(status), 32'b0100);
    check("condz_alu_a_held", 32'(alu_a), 32'h05);
    read_reg(2'd0, r);
    check("condz_reg0", 32'(r), 32'h0A);
    run_instr(enc_alu(OP_ADD, 2'd2, 2'd0, 2'd0, COND_C, 1'b1), 0, d, f, s, lat);
    check("condc_skipped", 32'(s), 32'd1);
    check("condc_data", 32'(d), 32'h00);
    check("condc_flags", 32'(f), 32'b0000);
    check("condc_status", 32'(status), 32'b0100);
    read_reg(2'd2, r);
    check("condc_reg2", 32'(r), 32'h80);

    // Response back-pressure with a competing instruction offered
    run_instr(enc_ldi(2'd1, 8'h5A), 5, d, f, s, lat);
    check("stall_data", 32'(d), 32'h5A);
    read_reg(2'd3, r);
    check("stall_no_accept", 32'(r), 32'h00);
    read_reg(2'd1, r);
    check("stall_reg1", 32'(r), 32'h5A);

    // Back-to-back LDIs with instr_valid and rsp_ready held high
    @(negedge clk);
    instr = enc_ldi(2'd3, 8'h3C);
    instr_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("b2b_ready", 32'(instr_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    rsp_ready = 1'b0;
    read_reg(2'd3, r);
    check("b2b_reg3", 32'(r), 32'h3C);

    // Async reset during ISSUE of 0xFF + 0x01
    run_instr(enc_ldi(2'd2, 8'hFF), 0, d, f, s, lat);
    run_instr(enc_ldi(2'd3, 8'h01), 0, d, f, s, lat);
    @(negedge clk);
    instr = enc_alu(OP_ADD, 2'd1, 2'd2, 2'd3, COND_AL, 1'b1);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    check("abort_in_issue", 32'(dbg_state), 32'(ST_ISSUE));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_status", 32'(status), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    read_reg(2'd1, r);
    check("abort_reg1", 32'(r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_rsp_idle", 32'(rsp_valid), 32'd0);
    check("abort_status_after", 32'(status), 32'd0);
    read_reg(2'd1, r);
    check("abort_reg1_after", 32'(r), 32'd0);

    // Three executed, two skipped (status is 0 after reset)
    run_instr(enc_ldi(2'd0, 8'h01), 0, d, f, s, lat);
    run_instr(enc_ldi(2'd1, 8'h02), 0, d, f, s, lat);
    run_instr(enc_alu(OP_ADD, 2'd2, 2'd0, 2'd1, COND_Z, 1'b0), 0, d, f, s, lat);
    check("cnt_skip_z", 32'(s), 32'd1);
    run_instr(enc_alu(OP_ADD, 2'd2, 2'd0, 2'd1, COND_N, 1'b0), 0, d, f, s, lat);
    check("cnt_skip_n", 32'(s), 32'd1);
    run_instr(enc_alu(OP_ADD, 2'd2, 2'd0, 2'd1, COND_AL, 1'b0), 0, d, f, s, lat);
    check("cnt_exec_data", 32'(d), 32'h03);
`ifdef ALU_PERF_CNT_EN
    check("perf_exec", 32'(perf_exec), 32'd3);
    check("perf_skip", 32'(perf_skip), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential front-end that drives the team's combinational 8-bit ALU as its initiator. It accepts instruction words over a valid/ready handshake and reads operands from a 4-entry register file. It issues registered A/B/opcode to the ALU and captures result plus flags. It then writes back, updates a sticky status register and returns a response over a second valid/ready handshake. Supports flag-conditional execution.

Parameters:
DATA_W, 8, operand/result width; must match ALU.
CNT_W, 16, width of perf counters (optional feature only).

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  block can accept instruction
instr  in  16  instruction word (format below)
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_W  written-back value (0 if skipped)
rsp_flags  out  4  {C,Z,N,V} captured for this instruction
rsp_skipped  out  1  condition failed, no writeback
alu_a  out  DATA_W  ALU operand A (registered)
alu_b  out  DATA_W  ALU operand B (registered)
alu_op  out  3  ALU opcode (registered)
alu_result  in  DATA_W  ALU result
alu_carry, alu_zero, alu_negative, alu_overflow  in  1 each  ALU flags
status  out  4  architectural flags {C,Z,N,V}
dbg_sel  in  2  register-file read select
dbg_data  out  DATA_W  combinational read of reg[dbg_sel]

Behaviour:
- Instr format: bit15=1 is LDI: rd=[14:13], imm=[7:0]. bit15=0 is ALU: op=[14:12], rd=[11:10], ra=[9:8], rb=[7:6], cond=[5:4] (00 always, 01 Z set, 10 C set, 11 N set), fupd=[3]; bits [2:0] ignored.
- Reset: FSM=IDLE; instr_ready=1; rsp_valid=0; rsp_data=0; rsp_flags=0; rsp_skipped=0; alu_a=alu_b=0; alu_op=0; status=0; all regs=0.
- FSM IDLE -> ISSUE -> CAPT -> RESP -> IDLE. instr_ready=1 only in IDLE. Handshake fires when instr_valid && instr_ready.
- IDLE: on handshake, latch instr. Condition is evaluated against status at this edge. Go to ISSUE.
- ISSUE: alu_a=reg[ra], alu_b=reg[rb], alu_op=op, all registered. The ALU settles combinationally. Go to CAPT.
- CAPT: if the condition passes, reg[rd]<=alu_result and rsp_data<=alu_result. If fupd=1, status<={carry,zero,negative,overflow}. rsp_flags always gets the ALU flags. If the condition fails: no writeback, status unchanged, rsp_data=0, rsp_skipped=1. Go to RESP with rsp_valid=1.
- LDI: skips the ALU. It goes IDLE -> CAPT directly and writes imm; status is unchanged; rsp_flags=status. Latency is 2 cycles to rsp_valid (ALU ops: 3).
- RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready, clear rsp_valid and return to IDLE, so instr_ready rises the next cycle. No new instruction is accepted until the response completes (one outstanding).
- alu_a/alu_b/alu_op hold their last issued value outside ISSUE.
- Condition uses pre-instruction status; status write ordering is strictly in-order.
- rd==ra/rb: operands are read in ISSUE before the CAPT write, so old values are used.
- Async reset mid-operation aborts the instruction, with no partial writeback; all outputs return to reset values immediately.

Optional Feature:
Macro ALU_PERF_CNT_EN. When defined, add outputs perf_exec[CNT_W] and perf_skip[CNT_W]. perf_exec increments on every executed writeback; perf_skip increments on every skipped instruction. Both saturate at all-ones and reset to 0. When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_ADD..OP_SHR (3'b000..3'b111);
  - cond constants COND_AL/Z/C/N;
  - flag bit indices FLG_C=3, FLG_Z=2, FLG_N=1, FLG_V=0;
  - the FSM state enum;
  - instruction field bit positions.
- One sub-module, alu_regfile_4x8: 4 x DATA_W registers, one write port, two sync-sampled read ports plus a combinational debug read, async active-low reset.

Test Plan:
- LDI r0=0x7F, LDI r1=0x01, ADD r2=r0,r1 fupd=1 -> rsp_data=0x80, rsp_flags C0 Z0 N1 V1, status=4'b0011, dbg reg2=0x80.
- LDI r0=0x05, SUB r3=r0,r0 fupd=1 -> rsp_data=0x00, Z=1; then a cond=01 ADD executes, and a cond=10 op returns rsp_skipped=1 with rd unchanged.
- Back-to-back LDIs with instr_valid held high -> instr_ready is low for exactly the cycles between handshake and response completion; 2-cycle LDI latency; 3-cycle ALU latency.
- rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stay stable, instr_ready stays 0, no second instruction is accepted.
- Assert rst_n low during ISSUE of ADD r1=0xFF+0x01 -> reg1=0, status=0, rsp_valid=0 immediately, instr_ready=1 after release.
- With ALU_PERF_CNT_EN defined: 3 executed + 2 skipped instructions -> perf_exec=3, perf_skip=2.
